// File: rtl/dma_controller_pkg.sv
// dma_controller_pkg: shared widths, FSM states, command opcodes
// and the burst-boundary helper for the DMA controller slice.
package dma_controller_pkg;

  localparam int DMA_WORD_SIZE   = 16;
  localparam int DMA_FETCH_SIZE  = 64;
  localparam int DMA_MEM_LATENCY = 4;
  localparam int DMA_BURST_WORDS = 4;
  localparam int DMA_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

  typedef enum logic {
    OP_NOP   = 1'b0,
    OP_BEGIN = 1'b1
  } dma_op_t;

  // True when idx is the final burst of a cnt-burst transfer.
  function automatic logic lastBurst(
    input logic [DMA_CNT_W-1:0] idx,
    input logic [DMA_CNT_W-1:0] cnt
  );
    return ({1'b0, idx} + 9'd1) >= {1'b0, cnt};
  endfunction

endpackage

// File: rtl/dma_controller_if.sv
// dma_controller_if: CPU command, bus arbitration and device
// buffer signals. master = DMA side, slave = CPU/device side.
interface dma_controller_if
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE  = DMA_WORD_SIZE,
  parameter int FETCH_SIZE = DMA_FETCH_SIZE
);

  logic                  cmd;
  logic [WORD_SIZE-1:0]  cmd_address;
  logic [DMA_CNT_W-1:0]  cmd_bursts;
  logic                  BG;
  logic                  BR;
  logic [FETCH_SIZE-1:0] dev_data;
  logic [DMA_CNT_W-1:0]  dev_index;
  logic                  dma_end;

  modport master (
    input  cmd,
    input  cmd_address,
    input  cmd_bursts,
    input  BG,
    input  dev_data,
    output BR,
    output dev_index,
    output dma_end
  );

  modport slave (
    output cmd,
    output cmd_address,
    output cmd_bursts,
    output BG,
    output dev_data,
    input  BR,
    input  dev_index,
    input  dma_end
  );

endinterface

// File: rtl/dma_controller.sv
// dma_controller: burst DMA from a device buffer into memory.
// Ports: Clk, Reset (async high), bus (cmd/BG/BR/dev/dma_end),
// d_writeM/d_address/d_data (tri-stated unless granted WRITE).
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE   = DMA_WORD_SIZE,
  parameter int FETCH_SIZE  = DMA_FETCH_SIZE,
  parameter int MEM_LATENCY = DMA_MEM_LATENCY
) (
  input  logic                  Clk,
  input  logic                  Reset,
  dma_controller_if.master      bus,
  output wire                   d_writeM,
  output wire [WORD_SIZE-1:0]   d_address,
  output wire [FETCH_SIZE-1:0]  d_data
);

  localparam int LW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  dma_state_t            state;
  dma_state_t            stateNext;
  logic [WORD_SIZE-1:0]  baseAddr;
  logic [DMA_CNT_W-1:0]  burstCnt;
  logic [DMA_CNT_W-1:0]  burstIdx;
  logic [LW-1:0]         latCnt;
  logic [FETCH_SIZE-1:0] dataReg;
  logic                  zeroEnd;

  logic                  cmdGo;
  logic                  latDone;
  logic                  isLast;
  logic [WORD_SIZE-1:0]  curAddr;

  logic                  brOut;
  logic                  endOut;
  logic                  drive;
  logic [DMA_CNT_W-1:0]  devIdx;

  assign cmdGo   = dma_op_t'(bus.cmd) == OP_BEGIN;
  assign latDone = latCnt == LW'(MEM_LATENCY - 1);
  assign isLast  = lastBurst(burstIdx, burstCnt);
  assign curAddr = baseAddr
    + WORD_SIZE'(burstIdx) * WORD_SIZE'(DMA_BURST_WORDS);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (cmdGo && bus.cmd_bursts != '0)
          stateNext = ST_REQ;
      end
      state == ST_REQ: begin
        if (bus.BG) stateNext = ST_WRITE;
      end
      state == ST_WRITE: begin
        if (!bus.BG)
          stateNext = ST_REQ;
        else if (latDone && isLast)
          stateNext = ST_DONE;
      end
      state == ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      baseAddr <= '0;
      burstCnt <= '0;
      burstIdx <= '0;
      latCnt   <= '0;
      dataReg  <= '0;
      zeroEnd  <= 1'b0;
    end else begin
      // Zero-length command completes without touching the bus.
      zeroEnd <= (state == ST_IDLE) && cmdGo
        && (bus.cmd_bursts == '0);
      unique case (1'b1)
        state == ST_IDLE: begin
          if (cmdGo && bus.cmd_bursts != '0) begin
            baseAddr <= bus.cmd_address;
            burstCnt <= bus.cmd_bursts;
            burstIdx <= '0;
            latCnt   <= '0;
          end
        end
        state == ST_REQ: begin
          // (Re)start of a burst: full latency, fresh data.
          if (bus.BG) begin
            latCnt  <= '0;
            dataReg <= bus.dev_data;
          end
        end
        state == ST_WRITE: begin
          if (bus.BG) begin
            if (!latDone) begin
              latCnt <= latCnt + LW'(1);
            end else if (!isLast) begin
              burstIdx <= burstIdx + 8'd1;
              latCnt   <= '0;
              dataReg  <= bus.dev_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    brOut  = 1'b0;
    endOut = zeroEnd;
    drive  = 1'b0;
    devIdx = burstIdx;
    unique case (1'b1)
      state == ST_REQ: brOut = 1'b1;
      state == ST_WRITE: begin
        brOut = 1'b1;
        drive = bus.BG;
        // Point the device at the next burst during the last
        // cycle so its data is ready at the back-to-back edge.
        if (latDone && !isLast)
          devIdx = burstIdx + 8'd1;
      end
      state == ST_DONE: endOut = 1'b1;
      default: ;
    endcase
  end

  assign bus.BR        = brOut;
  assign bus.dma_end   = endOut;
  assign bus.dev_index = devIdx;

  assign d_writeM  = drive ? 1'b1    : 1'bz;
  assign d_address = drive ? curAddr : 'z;
  assign d_data    = drive ? dataReg : 'z;

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameter WORD_SIZE, 16, address width in bits.
REQ-002 Parameter FETCH_SIZE, 64, burst data width (4 words per burst).
REQ-003 Parameter MEM_LATENCY, 4, cycles `d_writeM` is held per burst.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 cmd  input  1  one-cycle start pulse from CPU (dma_begin).
REQ-007 cmd_address  input  WORD_SIZE  memory base address, sampled with cmd.
REQ-008 cmd_bursts  input  8  number of 4-word bursts, sampled with cmd.
REQ-009 BG  input  1  bus grant from CPU.
REQ-010 BR  output  1  bus request to CPU.
REQ-011 dev_data  input  FETCH_SIZE  device buffer data for the current burst.
REQ-012 dev_index  output  8  index of the burst currently being read from the device.
REQ-013 d_writeM  output  1  memory write strobe; tri-stated when BG=0.
REQ-014 d_address  output  WORD_SIZE  memory write address; tri-stated when BG=0.
REQ-015 d_data  output  FETCH_SIZE  memory write data; tri-stated when BG=0.
REQ-016 dma_end  output  1  one-cycle completion pulse to CPU.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WRITE and DONE.
REQ-018 IDLE: on cmd=1 with cmd_bursts>0, latch address and count, clear burst index, and go to REQ the next cycle.
REQ-019 IDLE: on cmd=1 with cmd_bursts=0, pulse dma_end the next cycle, never assert BR, and stay in IDLE.
REQ-020 cmd while not IDLE SHALL be ignored; latched values stay unchanged.
REQ-021 BR SHALL be 1 exactly in REQ and WRITE, registered, and held continuously across all bursts.
REQ-022 REQ: BG=1 sampled on an edge SHALL move to WRITE with the latency counter cleared.
REQ-023 WRITE: drive d_writeM=1, d_address=base+4*index (mod 2^WORD_SIZE), d_data=dev_data registered at burst start, dev_index=index.
REQ-024 Each burst SHALL hold d_writeM and its address/data stable for exactly MEM_LATENCY consecutive cycles.
REQ-025 After MEM_LATENCY cycles, if index+1<bursts: increment index and start the next burst with no idle cycle; else go to DONE.
REQ-026 WRITE with BG=0 (grant lost) SHALL return to REQ, keep index, and restart the current burst's full latency on re-grant.
REQ-027 DONE: deassert BR, pulse dma_end for exactly one cycle, then go to IDLE.
REQ-028 d_writeM, d_address and d_data SHALL be high-Z whenever BG=0 or the state is not WRITE.
REQ-029 Address arithmetic SHALL wrap modulo 2^WORD_SIZE without error.
REQ-030 Total bus occupancy SHALL be bursts*MEM_LATENCY cycles in WRITE when the grant is never lost.

Reset
REQ-031 Reset=1 SHALL force IDLE, BR=0, dma_end=0, index=0, counters=0, and bus outputs high-Z, regardless of the clock.
REQ-032 Reset asserted mid-transfer SHALL abort without emitting dma_end; BR SHALL drop asynchronously.

Structure
REQ-033 WORD_SIZE, FETCH_SIZE, and the FSM state encodings SHALL live in a shared package/include alongside opcodes.
REQ-034 No sub-module; a single FSM with an address/index datapath.

Verification
REQ-035 cmd, cmd_address=0x01F4, cmd_bursts=3, BG one cycle after BR -> writes at 0x01F4, 0x01F8, 0x01FC, 4 cycles each; one dma_end pulse; BR low afterwards.
REQ-036 cmd_bursts=0 -> dma_end one cycle later; BR never asserted.
REQ-037 BG drops during the 2nd cycle of burst 1 and returns 5 cycles later -> burst 1 rewritten at the same address with the full 4 cycles; no bus drive while BG=0.
REQ-038 cmd_address=0xFFFC, cmd_bursts=2 -> second write at 0x0000.
REQ-039 Reset pulse in the middle of burst 2 -> BR=0 and bus high-Z immediately; no dma_end; a new cmd is accepted afterwards.
REQ-040 Second cmd during WRITE -> ignored; address sequence and burst count unchanged.
